execute_stage: RTL and testbench

Execute stage of the five-stage RV32I pipeline: the consumer of the ID/EX register bundle produced by the decode stage. Derives ALU control from ALUOp/funct3/funct7, computes the ALU result and branch decision/target, and registers everything into the EX/MEM pipeline register. Squashes wrong-path instructions after a taken branch, and optionally forwards results from MEM and WB.

---
 rtl/exec_pkg.sv | 50 +++++
 rtl/execute_stage_alu_core.sv | 38 +++
 rtl/execute_stage.sv | 179 +++++++++++++++++
 tb/tb_execute_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types and constants for the RV32I execute stage.
package exec_pkg;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
    } alu_op_e;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {FwdReg, FwdMem, FwdWb} fwd_sel_e;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        mem_to_reg;
        logic        mem_write;
        logic        mem_read;
        logic        reg_write;
        logic        branch_taken;
        logic [31:0] branch_target;
    } exmem_t;

    // alt selects SUB over ADD and SRA over SRL; ignored for other funct3 values.
    function automatic alu_op_e decode_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/execute_stage_alu_core.sv
// Combinational RV32I ALU with equality and signed/unsigned less-than flags.
module alu_core
    import exec_pkg::*;
(
    input  alu_op_e     op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o,
    output logic        eq_o,
    output logic        lt_o,
    output logic        ltu_o
);

    logic [4:0] shamt;

    assign shamt = b_i[4:0];
    assign eq_o  = (a_i == b_i);
    assign lt_o  = ($signed(a_i) < $signed(b_i));
    assign ltu_o = (a_i < b_i);

    always_comb begin
        result_o = '0;
        case (op_i)
            AluAdd:  result_o = a_i + b_i;
            AluSub:  result_o = a_i - b_i;
            AluSll:  result_o = a_i << shamt;
            AluSlt:  result_o = {31'b0, lt_o};
            AluSltu: result_o = {31'b0, ltu_o};
            AluXor:  result_o = a_i ^ b_i;
            AluSrl:  result_o = a_i >> shamt;
            AluSra:  result_o = 32'($signed(a_i) >>> shamt);
            AluOr:   result_o = a_i | b_i;
            AluAnd:  result_o = a_i & b_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: ALU control, branch resolution, wrong-path squash and EX/MEM register.
// Optional operand forwarding from MEM/WB is enabled by defining EXEC_FWD_EN.
module execute_stage
    import exec_pkg::*;
#(
    parameter int unsigned SQUASH_DEPTH = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
`ifdef EXEC_FWD_EN
    input  logic [4:0]  rs1_EXECUTE,
    input  logic [4:0]  rs2_EXECUTE,
`endif
    input  logic [31:0] pc_EXECUTE,
    input  logic [31:0] ReadData1_EXECUTE,
    input  logic [31:0] ReadData2_EXECUTE,
    input  logic [31:0] Immout_EXECUTE,
    input  logic [4:0]  Write_Register_EXECUTE,
    input  logic [2:0]  funct3_EXECUTE,
    input  logic        funct7_bit5_EXECUTE,
    input  logic        MemtoReg_EXECUTE,
    input  logic        MemWrite_EXECUTE,
    input  logic        MemRead_EXECUTE,
    input  logic        ALUSrc_EXECUTE,
    input  logic        RegWrite_EXECUTE,
    input  logic        Branch_EXECUTE,
    input  logic [1:0]  ALUOp_EXECUTE,
    input  logic [4:0]  Write_Register,
    input  logic        RegWrite,
    input  logic [31:0] Write_data,
    output logic [31:0] alu_result_MEMORY,
    output logic [31:0] store_data_MEMORY,
    output logic [4:0]  Write_Register_MEMORY,
    output logic        MemtoReg_MEMORY,
    output logic        MemWrite_MEMORY,
    output logic        MemRead_MEMORY,
    output logic        RegWrite_MEMORY,
    output logic        branch_taken_MEMORY,
    output logic [31:0] branch_target_MEMORY
);

    localparam int unsigned CntW = (SQUASH_DEPTH > 0) ? $clog2(SQUASH_DEPTH + 1) : 1;
    localparam logic StIdle   = 1'b0;
    localparam logic StSquash = 1'b1;

    exmem_t      exmem_d, exmem_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic        state;
    logic        kill;
    logic        cond;
    logic        taken;
    logic [31:0] op_a, rs2_val, op_b, alu_result;
    logic        eq, lt, ltu;
    alu_op_e     alu_op;

`ifdef EXEC_FWD_EN
    fwd_sel_e fwd_a_sel, fwd_b_sel;
    logic     mem_fwd_ok, wb_fwd_ok;

    // Loads in MEM have no data yet; the hazard unit stalls those instead.
    assign mem_fwd_ok = exmem_q.reg_write & ~exmem_q.mem_read & (exmem_q.rd != 5'd0);
    assign wb_fwd_ok  = RegWrite & (Write_Register != 5'd0);

    always_comb begin
        fwd_a_sel = FwdReg;
        if (mem_fwd_ok && exmem_q.rd == rs1_EXECUTE) begin
            fwd_a_sel = FwdMem;
        end else if (wb_fwd_ok && Write_Register == rs1_EXECUTE) begin
            fwd_a_sel = FwdWb;
        end
        fwd_b_sel = FwdReg;
        if (mem_fwd_ok && exmem_q.rd == rs2_EXECUTE) begin
            fwd_b_sel = FwdMem;
        end else if (wb_fwd_ok && Write_Register == rs2_EXECUTE) begin
            fwd_b_sel = FwdWb;
        end
    end

    always_comb begin
        case (fwd_a_sel)
            FwdMem:  op_a = exmem_q.alu_result;
            FwdWb:   op_a = Write_data;
            default: op_a = ReadData1_EXECUTE;
        endcase
        case (fwd_b_sel)
            FwdMem:  rs2_val = exmem_q.alu_result;
            FwdWb:   rs2_val = Write_data;
            default: rs2_val = ReadData2_EXECUTE;
        endcase
    end
`else
    logic unused_wb;

    assign unused_wb = ^{Write_Register, RegWrite, Write_data};
    assign op_a      = ReadData1_EXECUTE;
    assign rs2_val   = ReadData2_EXECUTE;
`endif

    assign op_b = ALUSrc_EXECUTE ? Immout_EXECUTE : rs2_val;

    // I-type only honours funct7 bit 5 for SRAI; ADDI must never become SUB.
    always_comb begin
        case (ALUOp_EXECUTE)
            ALUOP_MEM: alu_op = AluAdd;
            ALUOP_BR:  alu_op = AluSub;
            ALUOP_R:   alu_op = decode_funct3(funct3_EXECUTE, funct7_bit5_EXECUTE);
            default:   alu_op = decode_funct3(funct3_EXECUTE,
                                              funct7_bit5_EXECUTE & (funct3_EXECUTE == 3'b101));
        endcase
    end

    alu_core u_alu_core (
        .op_i     (alu_op),
        .a_i      (op_a),
        .b_i      (op_b),
        .result_o (alu_result),
        .eq_o     (eq),
        .lt_o     (lt),
        .ltu_o    (ltu)
    );

    always_comb begin
        case (funct3_EXECUTE)
            F3_BEQ:  cond = eq;
            F3_BNE:  cond = ~eq;
            F3_BLT:  cond = lt;
            F3_BGE:  cond = ~lt;
            F3_BLTU: cond = ltu;
            F3_BGEU: cond = ~ltu;
            default: cond = 1'b0;
        endcase
    end

    assign state = (cnt_q != '0) ? StSquash : StIdle;
    assign kill  = (state == StSquash);
    assign taken = Branch_EXECUTE & cond & ~kill;

    always_comb begin
        cnt_d = cnt_q;
        case (state)
            StIdle:   if (taken) cnt_d = CntW'(SQUASH_DEPTH);
            default:  cnt_d = cnt_q - CntW'(1);
        endcase
    end

    always_comb begin
        exmem_d               = '0;
        exmem_d.alu_result    = alu_result;
        exmem_d.store_data    = rs2_val;
        exmem_d.rd            = Write_Register_EXECUTE;
        exmem_d.mem_to_reg    = MemtoReg_EXECUTE;
        exmem_d.mem_write     = MemWrite_EXECUTE & ~kill;
        exmem_d.mem_read      = MemRead_EXECUTE & ~kill;
        exmem_d.reg_write     = RegWrite_EXECUTE & ~kill;
        exmem_d.branch_taken  = taken;
        exmem_d.branch_target = pc_EXECUTE + Immout_EXECUTE;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            exmem_q <= '0;
            cnt_q   <= '0;
        end else begin
            exmem_q <= exmem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign alu_result_MEMORY     = exmem_q.alu_result;
    assign store_data_MEMORY     = exmem_q.store_data;
    assign Write_Register_MEMORY = exmem_q.rd;
    assign MemtoReg_MEMORY       = exmem_q.mem_to_reg;
    assign MemWrite_MEMORY       = exmem_q.mem_write;
    assign MemRead_MEMORY        = exmem_q.mem_read;
    assign RegWrite_MEMORY       = exmem_q.reg_write;
    assign branch_taken_MEMORY   = exmem_q.branch_taken;
    assign branch_target_MEMORY  = exmem_q.branch_target;

endmodule

// File: tb/tb_execute_stage.sv
// Table-driven scoreboard bench for execute_stage; forwarding vectors need EXEC_FWD_EN.
module tb_execute_stage;

    typedef struct {
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rd, rs1, rs2, wb_rd;
        logic        wb_we;
        logic [31:0] wb_data;
        logic [2:0]  f3;
        logic        f7;
        logic [1:0]  aluop;
        logic        alusrc, branch, memtoreg, memwrite, memread, regwrite;
        logic [31:0] exp_alu, exp_store;
        logic        exp_taken, exp_kill, chk_alu;
    } vec_t;

    typedef struct {
        logic [31:0] alu, store, tgt;
        logic [4:0]  rd;
        logic [3:0]  ctl;
        logic        taken, chk_data, chk_alu;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [4:0]  rs1, rs2;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  wr_ex;
    logic [2:0]  f3;
    logic        f7, memtoreg, memwrite, memread, alusrc, regwrite, branch;
    logic [1:0]  aluop;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wb_data;
    logic [31:0] alu_m, store_m, tgt_m;
    logic [4:0]  wr_m;
    logic        memtoreg_m, memwrite_m, memread_m, regwrite_m, taken_m;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    execute_stage dut (
        .clk_i                  (clk),
        .reset_i                (reset_i),
`ifdef EXEC_FWD_EN
        .rs1_EXECUTE            (rs1),
        .rs2_EXECUTE            (rs2),
`endif
        .pc_EXECUTE             (pc),
        .ReadData1_EXECUTE      (rd1),
        .ReadData2_EXECUTE      (rd2),
        .Immout_EXECUTE         (imm),
        .Write_Register_EXECUTE (wr_ex),
        .funct3_EXECUTE         (f3),
        .funct7_bit5_EXECUTE    (f7),
        .MemtoReg_EXECUTE       (memtoreg),
        .MemWrite_EXECUTE       (memwrite),
        .MemRead_EXECUTE        (memread),
        .ALUSrc_EXECUTE         (alusrc),
        .RegWrite_EXECUTE       (regwrite),
        .Branch_EXECUTE         (branch),
        .ALUOp_EXECUTE          (aluop),
        .Write_Register         (wb_rd),
        .RegWrite               (wb_we),
        .Write_data             (wb_data),
        .alu_result_MEMORY      (alu_m),
        .store_data_MEMORY      (store_m),
        .Write_Register_MEMORY  (wr_m),
        .MemtoReg_MEMORY        (memtoreg_m),
        .MemWrite_MEMORY        (memwrite_m),
        .MemRead_MEMORY         (memread_m),
        .RegWrite_MEMORY        (regwrite_m),
        .branch_taken_MEMORY    (taken_m),
        .branch_target_MEMORY   (tgt_m)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t blank();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    function automatic vec_t r_op(logic [2:0] fn3, logic fn7, logic [31:0] a, logic [31:0] b,
                                  logic [31:0] exp);
        vec_t v = blank();
        v.aluop = 2'b10; v.f3 = fn3; v.f7 = fn7; v.a = a; v.b = b; v.rd = 5'd3;
        v.regwrite = 1'b1; v.exp_alu = exp; v.exp_store = b; v.chk_alu = 1'b1;
        return v;
    endfunction

    function automatic vec_t i_op(logic [2:0] fn3, logic fn7, logic [31:0] a, logic [31:0] im,
                                  logic [31:0] exp);
        vec_t v = blank();
        v.aluop = 2'b11; v.alusrc = 1'b1; v.f3 = fn3; v.f7 = fn7; v.a = a; v.imm = im;
        v.rd = 5'd4; v.regwrite = 1'b1; v.exp_alu = exp; v.chk_alu = 1'b1;
        return v;
    endfunction

    function automatic vec_t br(logic [2:0] fn3, logic [31:0] a, logic [31:0] b,
                                logic [31:0] p, logic [31:0] im, logic tk);
        vec_t v = blank();
        v.aluop = 2'b01; v.branch = 1'b1; v.f3 = fn3; v.a = a; v.b = b; v.pc = p; v.imm = im;
        v.exp_taken = tk; v.exp_store = b;
        return v;
    endfunction

    function automatic vec_t mem_op(logic ld, logic [31:0] a, logic [31:0] im, logic [31:0] d);
        vec_t v = blank();
        v.aluop = 2'b00; v.alusrc = 1'b1; v.a = a; v.imm = im; v.b = d; v.exp_store = d;
        v.memread = ld; v.memtoreg = ld; v.regwrite = ld; v.memwrite = ~ld;
        v.rd = ld ? 5'd7 : 5'd0; v.exp_alu = a + im; v.chk_alu = 1'b1;
        return v;
    endfunction

    function automatic vec_t killed(vec_t v_in);
        vec_t v = v_in;
        v.exp_kill = 1'b1;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        pc = v.pc; rd1 = v.a; rd2 = v.b; imm = v.imm; wr_ex = v.rd; f3 = v.f3; f7 = v.f7;
        memtoreg = v.memtoreg; memwrite = v.memwrite; memread = v.memread; alusrc = v.alusrc;
        regwrite = v.regwrite; branch = v.branch; aluop = v.aluop;
        rs1 = v.rs1; rs2 = v.rs2; wb_rd = v.wb_rd; wb_we = v.wb_we; wb_data = v.wb_data;
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        drive(v);
        e.ctl = v.exp_kill ? {v.memtoreg, 3'b000}
                           : {v.memtoreg, v.memwrite, v.memread, v.regwrite};
        e.taken = v.exp_kill ? 1'b0 : v.exp_taken;
        e.alu = v.exp_alu; e.store = v.exp_store; e.tgt = v.pc + v.imm; e.rd = v.rd;
        e.chk_data = ~v.exp_kill; e.chk_alu = v.chk_alu & ~v.exp_kill;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("ctl{m2r,mw,mr,rw}", {28'd0, memtoreg_m, memwrite_m, memread_m, regwrite_m},
                {28'd0, e.ctl});
            chk("branch_taken", {31'd0, taken_m}, {31'd0, e.taken});
            if (e.chk_data) begin
                chk("rd", {27'd0, wr_m}, {27'd0, e.rd});
                chk("store_data", store_m, e.store);
                chk("target", tgt_m, e.tgt);
            end
            if (e.chk_alu) chk("alu_result", alu_m, e.alu);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_alu"}, alu_m, 32'd0);
        chk({tag, "_store"}, store_m, 32'd0);
        chk({tag, "_target"}, tgt_m, 32'd0);
        chk({tag, "_rd"}, {27'd0, wr_m}, 32'd0);
        chk({tag, "_ctl"}, {27'd0, memtoreg_m, memwrite_m, memread_m, regwrite_m, taken_m},
            32'd0);
    endtask

    initial begin
        vec_t v;
        reset_i = 1'b1;
        v = r_op(3'b000, 1'b0, 32'd1, 32'd1, 32'd2);
        drive(v);
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset_i = 1'b0;

        // R-type with A=0xFFFFFFF0
        tbl.push_back(r_op(3'b000, 1'b0, 32'hFFFF_FFF0, 32'h10, 32'h0000_0000));
        tbl.push_back(r_op(3'b000, 1'b1, 32'hFFFF_FFF0, 32'h10, 32'hFFFF_FFE0));
        tbl.push_back(r_op(3'b001, 1'b0, 32'hFFFF_FFF0, 32'h10, 32'hFFF0_0000));
        tbl.push_back(r_op(3'b010, 1'b0, 32'hFFFF_FFF0, 32'h10, 32'h1));
        tbl.push_back(r_op(3'b011, 1'b0, 32'hFFFF_FFF0, 32'h10, 32'h0));
        tbl.push_back(r_op(3'b100, 1'b0, 32'hFFFF_FFF0, 32'h10, 32'hFFFF_FFE0));
        tbl.push_back(r_op(3'b101, 1'b1, 32'hFFFF_FFF0, 32'h4, 32'hFFFF_FFFF));
        tbl.push_back(r_op(3'b101, 1'b0, 32'hFFFF_FFF0, 32'h4, 32'h0FFF_FFFF));
        tbl.push_back(r_op(3'b110, 1'b0, 32'hFFFF_FFF0, 32'h10, 32'hFFFF_FFF0));
        tbl.push_back(r_op(3'b111, 1'b0, 32'hFFFF_FFF0, 32'h10, 32'h0000_0010));
        // I-type: bit5 only matters for funct3=101
        tbl.push_back(i_op(3'b000, 1'b1, 32'd10, 32'd5, 32'd15));
        tbl.push_back(i_op(3'b101, 1'b1, 32'h8000_0000, 32'h404, 32'hF800_0000));
        tbl.push_back(i_op(3'b101, 1'b0, 32'h8000_0000, 32'h004, 32'h0800_0000));
        tbl.push_back(i_op(3'b010, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h1));
        tbl.push_back(mem_op(1'b1, 32'h1000, 32'h10, 32'h0));
        tbl.push_back(mem_op(1'b0, 32'h2000, 32'h8, 32'hDEAD_BEEF));
        // BLTU taken, then three killed (incl. a taken-looking branch and a store)
        tbl.push_back(br(3'b110, 32'd1, 32'd2, 32'h100, 32'h20, 1'b1));
        tbl.push_back(killed(r_op(3'b000, 1'b0, 32'd5, 32'd6, 32'd11)));
        tbl.push_back(killed(br(3'b000, 32'd5, 32'd5, 32'h200, 32'h40, 1'b1)));
        tbl.push_back(killed(mem_op(1'b0, 32'h3000, 32'h4, 32'h1234_5678)));
        tbl.push_back(r_op(3'b000, 1'b0, 32'd1, 32'd2, 32'd3));
        // Not-taken BEQ must not squash
        tbl.push_back(br(3'b000, 32'd1, 32'd2, 32'h300, 32'h10, 1'b0));
        tbl.push_back(r_op(3'b100, 1'b0, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F));
        tbl.push_back(br(3'b101, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h8, 1'b0));
        tbl.push_back(br(3'b010, 32'd0, 32'd0, 32'h404, 32'h8, 1'b0));
        // Target wraps modulo 2^32
        tbl.push_back(br(3'b111, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 32'h20, 1'b1));
        tbl.push_back(killed(mem_op(1'b1, 32'h10, 32'h0, 32'h0)));
        tbl.push_back(killed(r_op(3'b000, 1'b0, 32'd7, 32'd7, 32'd14)));
        tbl.push_back(killed(r_op(3'b000, 1'b0, 32'd8, 32'd8, 32'd16)));
        tbl.push_back(mem_op(1'b1, 32'h20, 32'h4, 32'h0));
`ifdef EXEC_FWD_EN
        v = r_op(3'b000, 1'b0, 32'd3, 32'd4, 32'd7); v.rd = 5'd5; tbl.push_back(v);
        v = r_op(3'b000, 1'b0, 32'd0, 32'd0, 32'd14);
        v.rs1 = 5'd5; v.rs2 = 5'd5; v.rd = 5'd6; v.exp_store = 32'd7; tbl.push_back(v);
        v = r_op(3'b000, 1'b0, 32'd0, 32'd0, 32'd28);
        v.rs1 = 5'd6; v.rs2 = 5'd6; v.wb_rd = 5'd6; v.wb_we = 1'b1; v.wb_data = 32'd100;
        v.exp_store = 32'd14; tbl.push_back(v);
        v = r_op(3'b000, 1'b0, 32'd1, 32'd1, 32'd2); v.rd = 5'd0; tbl.push_back(v);
        v = r_op(3'b000, 1'b0, 32'd0, 32'd0, 32'd0);
        v.wb_rd = 5'd0; v.wb_we = 1'b1; v.wb_data = 32'd55; tbl.push_back(v);
        tbl.push_back(mem_op(1'b1, 32'h1000, 32'h4, 32'h0));
        v = r_op(3'b000, 1'b0, 32'd9, 32'd0, 32'h50);
        v.rs1 = 5'd7; v.wb_rd = 5'd7; v.wb_we = 1'b1; v.wb_data = 32'h50; tbl.push_back(v);
`endif

        foreach (tbl[i]) apply(tbl[i]);

        // Reset during a squash must clear the counter
        apply(br(3'b001, 32'd1, 32'd2, 32'h500, 32'h10, 1'b1));
        apply(killed(r_op(3'b000, 1'b0, 32'd2, 32'd2, 32'd4)));
        reset_i = 1'b1;
        drive(r_op(3'b000, 1'b0, 32'd3, 32'd3, 32'd6));
        @(posedge clk);
        #1;
        chk_zero("midreset1");
        @(posedge clk);
        #1;
        chk_zero("midreset2");
        reset_i = 1'b0;
        apply(r_op(3'b110, 1'b0, 32'h0F00, 32'h00F0, 32'h0FF0));
        apply(r_op(3'b000, 1'b1, 32'd0, 32'd1, 32'hFFFF_FFFF));

        if (sb.size() != 0) chk("scoreboard_leftover", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
